// File: rtl/vsq_pkg.sv
// Shared constants for the VSQ quantizer group datapath.
// Controller state encoding and reciprocal divider sizing.
package vsq_pkg;
    localparam int LANES      = 16;
    localparam int IN_W       = 18;
    localparam int QW         = 8;
    localparam int GROUP      = 16;
    localparam int RF         = 18;
    localparam int DIV_CYCLES = QW + RF;
    localparam int PROD_W     = IN_W + QW + RF;

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] DIV   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
endpackage

// File: rtl/vsq_recip_div.sv
// Restoring divider: quot = ((2^QW-1) << RF) / divisor, one bit per cycle.
// A zero divisor yields a zero quotient.
module vsq_recip_div
    import vsq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [IN_W-1:0]       divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DIV_CYCLES-1:0] quot_o
);
    localparam int SW = $clog2(DIV_CYCLES);
    localparam logic [DIV_CYCLES-1:0] DIVIDEND = {{QW{1'b1}}, {RF{1'b0}}};

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [SW-1:0]         step_q, step_d;
    logic [IN_W-1:0]       rem_q, rem_d;
    logic [DIV_CYCLES-1:0] quot_q, quot_d;
    logic [IN_W:0]         trial;
    logic                  fits;

    assign trial = {rem_q, DIVIDEND[SW'(DIV_CYCLES - 1) - step_q]};
    assign fits  = (divisor_i != '0) && (trial >= {1'b0, divisor_i});

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        step_d = step_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        if (start_i) begin
            busy_d = 1'b1;
            step_d = '0;
            rem_d  = '0;
            quot_d = '0;
        end else if (busy_q) begin
            if (fits) begin
                rem_d  = IN_W'(trial - {1'b0, divisor_i});
                quot_d = {quot_q[DIV_CYCLES-2:0], 1'b1};
            end else begin
                rem_d  = trial[IN_W-1:0];
                quot_d = {quot_q[DIV_CYCLES-2:0], 1'b0};
            end
            step_d = step_q + SW'(1);
            if (step_q == SW'(DIV_CYCLES - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            step_q <= '0;
            rem_q  <= '0;
            quot_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            step_q <= step_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = quot_q;
endmodule

// File: rtl/vsq_quantizer.sv
// Group-scaled 8-bit quantizer: buffer a group, divide, drain.
// VSQ_ROUND_EN selects round-half-up; otherwise truncation.
module vsq_quantizer
    import vsq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*QW-1:0]   out_data,
    output logic [IN_W-1:0]       out_scale,
    output logic                  out_last
);
    localparam int CW = $clog2(GROUP);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IN_W-1:0]       max_q, max_d;
    logic [IN_W-1:0]       grp_max;
    logic [LANES*IN_W-1:0] mem_q [GROUP];
    logic [LANES*IN_W-1:0] rd_vec;
    logic [IN_W-1:0]       lane_x [LANES];
    logic                  grp_end;
    logic                  div_start;
    logic                  div_busy;
    logic                  div_done;
    logic [DIV_CYCLES-1:0] recip;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign grp_end   = (cnt_q == CW'(GROUP - 1));
    assign out_last  = out_valid && grp_end;
    assign out_scale = out_valid ? max_q : '0;
    assign rd_vec    = mem_q[cnt_q];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_x[g] = in_data[g*IN_W +: IN_W];
    end

    // Incoming vector joins the running max in the same cycle.
    always_comb begin
        grp_max = max_q;
        for (int i = 0; i < LANES; i++) begin
            if (lane_x[i] > grp_max) grp_max = lane_x[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        div_start = 1'b0;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    max_d = grp_max;
                    if (grp_end) begin
                        cnt_d     = '0;
                        state_d   = DIV;
                        div_start = 1'b1;
                    end
                end
            end
            DIV: begin
                if (div_done && !div_busy) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_ready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (grp_end) begin
                        cnt_d   = '0;
                        max_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) mem_q[cnt_q] <= in_data;
    end

    vsq_recip_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (div_start),
        .divisor_i (max_q),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quot_o    (recip)
    );

`ifdef VSQ_ROUND_EN
    localparam logic [PROD_W-1:0] HALF = PROD_W'(1) << (RF - 1);
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_q
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] sh;
        assign prod = PROD_W'(rd_vec[g*IN_W +: IN_W]) * PROD_W'(recip);
`ifdef VSQ_ROUND_EN
        assign sh = (prod + HALF) >> RF;
`else
        assign sh = prod >> RF;
`endif
        assign out_data[g*QW +: QW] = !out_valid ? '0 :
                                      (|sh[PROD_W-1:QW]) ? '1 :
                                      sh[QW-1:0];
    end
endmodule

// File: tb/tb_vsq_quantizer.sv
// Randomized bench for vsq_quantizer against a group-level reference model.
// Honours VSQ_ROUND_EN the same way as the design.
module tb_vsq_quantizer;
    localparam int L  = 16;
    localparam int W  = 18;
    localparam int G  = 16;
    localparam int DC = 26;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [L*W-1:0] in_data = '0;
    logic           in_ready;
    logic           out_valid;
    logic           out_last;
    logic [L*8-1:0] out_data;
    logic [W-1:0]   out_scale;

    vsq_quantizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_scale (out_scale),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int             m_phase, m_cnt, m_div, m_idx;
    longint         m_max, m_R;
    logic [L*W-1:0] m_vec [G];
    int             hs_cnt, last_cnt;
    logic [L*8-1:0] obs [G];
    logic [W-1:0]   obs_scale;
    logic           rand_rdy = 1'b0;
    logic [L*W-1:0] grp [G];

    function automatic logic [L*8-1:0] qvec(input logic [L*W-1:0] v,
                                            input longint r);
        logic [L*8-1:0] o;
        longint p;
        o = '0;
        for (int i = 0; i < L; i++) begin
            p = longint'(v[i*W +: W]) * r;
`ifdef VSQ_ROUND_EN
            p = p + (longint'(1) << 17);
`endif
            p = p >> 18;
            if (p > 255) p = 255;
            o[i*8 +: 8] = p[7:0];
        end
        return o;
    endfunction

    initial begin
        logic           s_rst, s_iv, s_or;
        logic [L*W-1:0] s_d;
        s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b0; s_d = '0;
        m_phase = 0; m_cnt = 0; m_max = 0; m_R = 0;
        m_div = 0; m_idx = 0; hs_cnt = 0; last_cnt = 0;
        forever begin
            @(posedge clk);
            if (s_rst) begin
                m_phase = 0; m_cnt = 0; m_max = 0;
            end else begin
                case (m_phase)
                    0: if (s_iv) begin
                        m_vec[m_cnt] = s_d;
                        for (int i = 0; i < L; i++)
                            if (longint'(s_d[i*W +: W]) > m_max)
                                m_max = longint'(s_d[i*W +: W]);
                        m_cnt++;
                        if (m_cnt == G) begin
                            m_cnt = 0; m_phase = 1; m_div = 0;
                            hs_cnt = 0; last_cnt = 0;
                        end
                    end
                    1: begin
                        m_div++;
                        if (m_div == DC + 1) begin
                            m_phase = 2; m_idx = 0;
                            m_R = (m_max == 0) ? 0 :
                                  (longint'(255) << 18) / m_max;
                        end
                    end
                    default: if (s_or) begin
                        m_idx++;
                        if (m_idx == G) begin
                            m_phase = 0; m_max = 0;
                        end
                    end
                endcase
            end
            @(negedge clk);
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("out_data", out_data, qvec(m_vec[m_idx], m_R));
                chk("out_scale", out_scale, m_max[W-1:0]);
                chk("out_last", out_last, m_idx == G - 1);
                if (out_ready) begin
                    if (hs_cnt < G) obs[hs_cnt] = out_data;
                    if (hs_cnt == 0) obs_scale = out_scale;
                    last_cnt += int'(out_last);
                    hs_cnt++;
                end
            end
            s_rst = rst; s_iv = in_valid; s_or = out_ready; s_d = in_data;
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [L*W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("send_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_grp(input int gaps);
        for (int k = 0; k < G; k++) begin
            send(grp[k]);
            if (gaps != 0) repeat ($urandom_range(0, gaps)) tick();
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready && !out_valid) && n < 2000) begin
            tick();
            n++;
        end
        chk("idle_reached", {in_ready, out_valid}, 2'b10);
    endtask

    task automatic fill_rand(input int maxv);
        for (int k = 0; k < G; k++)
            for (int i = 0; i < L; i++)
                grp[k][i*W +: W] = W'($urandom_range(0, maxv));
    endtask

    task automatic fill_zero();
        for (int k = 0; k < G; k++) grp[k] = '0;
    endtask

    int             n;
    logic [L*8-1:0] snap;
    logic [W-1:0]   snap_s;
    logic [W-1:0]   emax;

    initial begin
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_scale", out_scale, 0);

        // Sparse group: scale 1000, R 66846.
        fill_zero();
        grp[3][7*W +: W] = 18'd1000;
        grp[5][2*W +: W] = 18'd500;
        out_ready = 1'b1;
        send_grp(0);
        wait_valid(n);
        chk("div_latency", n, 27);
        wait_idle();
        chk("sparse_R", m_R, 66846);
        chk("sparse_scale", obs_scale, 1000);
`ifdef VSQ_ROUND_EN
        chk("sparse_v3l7", obs[3][7*8 +: 8], 255);
`else
        chk("sparse_v3l7", obs[3][7*8 +: 8], 254);
`endif
        chk("sparse_v5l2", obs[5][2*8 +: 8], 127);
        chk("sparse_hs", hs_cnt, 16);
        chk("sparse_last", last_cnt, 1);

        // All-zero group.
        fill_zero();
        send_grp(0);
        wait_valid(n);
        chk("zero_latency", n, 27);
        wait_idle();
        chk("zero_scale", obs_scale, 0);
        for (int k = 0; k < G; k++) chk("zero_data", obs[k], 0);

        // Backpressure during output 4.
        fill_rand(262143);
        out_ready = 1'b0;
        send_grp(1);
        for (int k = 0; k < G; k++) begin
            wait_valid(n);
            chk("bp_valid", out_valid, 1);
            chk("bp_last", out_last, k == G - 1);
            if (k == 4) begin
                snap   = out_data;
                snap_s = out_scale;
                repeat (5) tick();
                chk("bp_stable_data", out_data, snap);
                chk("bp_stable_scale", out_scale, snap_s);
                chk("bp_stable_last", out_last, 0);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("bp_done", out_valid, 0);
        chk("bp_hs", hs_cnt, 16);
        chk("bp_last_cnt", last_cnt, 1);
        wait_idle();

        // Full-scale value in the top lane.
        fill_zero();
        grp[0][15*W +: W] = 18'h3FFFF;
        out_ready = 1'b1;
        send_grp(0);
        wait_idle();
        chk("top_scale", obs_scale, 262143);
`ifdef VSQ_ROUND_EN
        chk("top_lane", obs[0][15*8 +: 8], 255);
`else
        chk("top_lane", obs[0][15*8 +: 8], 254);
`endif

        // Reset after a partial group.
        fill_rand(262143);
        grp[0][0 +: W] = 18'd250000;
        for (int k = 0; k < 9; k++) send(grp[k]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("prst_in_ready", in_ready, 1);
        chk("prst_out_valid", out_valid, 0);
        fill_rand(1000);
        emax = '0;
        for (int k = 0; k < G; k++)
            for (int i = 0; i < L; i++)
                if (grp[k][i*W +: W] > emax) emax = grp[k][i*W +: W];
        send_grp(0);
        wait_idle();
        chk("prst_scale", obs_scale, emax);

        // Reset during drain.
        fill_rand(5000);
        out_ready = 1'b0;
        send_grp(0);
        wait_valid(n);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("drst_out_valid", out_valid, 0);
        chk("drst_in_ready", in_ready, 1);

        // Random groups with random gaps and backpressure.
        rand_rdy = 1'b1;
        for (int r = 0; r < 5; r++) begin
            case (r)
                0: fill_rand(1);
                1: fill_rand(3);
                2: fill_rand(255);
                3: fill_rand(70000);
                default: fill_rand(262143);
            endcase
            send_grp(2);
            wait_idle();
            chk("rand_hs", hs_cnt, 16);
        end
        rand_rdy = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
